// File: rtl/vga_stream_out.sv
// AXI4-Stream to VGA output stage: free-running raster counters, frame/line lock to
// tuser/tlast with automatic re-lock, registered sync/colour/de and error pulses.
module vga_stream_out #(
    parameter int unsigned          COLOR_W     = 4,
    parameter int unsigned          H_RES       = 640,
    parameter int unsigned          H_FP        = 16,
    parameter int unsigned          H_SYNC      = 96,
    parameter int unsigned          H_BP        = 48,
    parameter int unsigned          V_RES       = 480,
    parameter int unsigned          V_FP        = 10,
    parameter int unsigned          V_SYNC      = 2,
    parameter int unsigned          V_BP        = 33,
    parameter bit                   HSYNC_POL   = 1'b0,
    parameter bit                   VSYNC_POL   = 1'b0,
    parameter logic [3*COLOR_W-1:0] BLANK_COLOR = '0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 pix_tvalid,
    output logic                 pix_tready,
    input  logic [3*COLOR_W-1:0] pix_tdata,
    input  logic                 pix_tlast,
    input  logic                 pix_tuser,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 de,
    output logic                 sof,
    output logic                 underflow,
    output logic                 sync_err
);

    localparam int unsigned H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int unsigned VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    localparam int unsigned H_SYNC_BEG = H_RES + H_FP;
    localparam int unsigned H_SYNC_END = H_RES + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_RES + V_FP;
    localparam int unsigned V_SYNC_END = V_RES + V_FP + V_SYNC;

    typedef enum logic {
        StSearch,
        StLocked
    } state_t;

    logic [HW-1:0]        r_h_cnt;
    logic [VW-1:0]        r_v_cnt;
    state_t               r_state;
    state_t               w_state_d;

    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_de;
    logic [3*COLOR_W-1:0] r_rgb;
    logic                 r_sof;
    logic                 r_underflow;
    logic                 r_sync_err;

    logic [31:0]          w_h;
    logic [31:0]          w_v;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic                 w_active;
    logic                 w_origin;
    logic                 w_line_end;
    logic                 w_hs_region;
    logic                 w_vs_region;
    logic                 w_head_sof;
    logic                 w_flag_err;
    logic                 w_show;
    logic                 w_underflow;
    logic                 w_sync_err;
    logic                 w_sof;

    // Compare positions at 32 bits so the timing parameters need no resizing.
    assign w_h = 32'(r_h_cnt);
    assign w_v = 32'(r_v_cnt);

    assign w_h_wrap    = (w_h == H_TOT - 1);
    assign w_v_wrap    = (w_v == V_TOT - 1);
    assign w_active    = (w_h < H_RES) && (w_v < V_RES);
    assign w_origin    = (w_h == 0) && (w_v == 0);
    assign w_line_end  = (w_h == H_RES - 1);
    assign w_hs_region = (w_h >= H_SYNC_BEG) && (w_h < H_SYNC_END);
    assign w_vs_region = (w_v >= V_SYNC_BEG) && (w_v < V_SYNC_END);

    assign w_head_sof  = pix_tvalid && pix_tuser;
    assign w_flag_err  = (pix_tuser != w_origin) || (pix_tlast != w_line_end);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= StSearch;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        pix_tready  = 1'b0;
        w_show      = 1'b0;
        w_underflow = 1'b0;
        w_sync_err  = 1'b0;
        case (r_state)
            StSearch: begin
                // Drain anything that is not a frame start; hold a frame start for (0,0).
                pix_tready = !w_head_sof || w_origin;
                if (w_head_sof && w_origin) begin
                    w_show    = 1'b1;
                    w_state_d = StLocked;
                end
            end
            StLocked: begin
                pix_tready = w_active;
                if (w_active) begin
                    if (!pix_tvalid) begin
                        w_underflow = 1'b1;
                        w_state_d   = StSearch;
                    end else begin
                        w_show = 1'b1;
                        if (w_flag_err) begin
                            w_sync_err = 1'b1;
                            w_state_d  = StSearch;
                        end
                    end
                end
            end
            default: begin
                w_state_d = StSearch;
            end
        endcase
    end

    assign w_sof = w_show && w_origin && pix_tuser;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hsync     <= ~HSYNC_POL;
            r_vsync     <= ~VSYNC_POL;
            r_de        <= 1'b0;
            r_rgb       <= BLANK_COLOR;
            r_sof       <= 1'b0;
            r_underflow <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_hsync     <= w_hs_region ? HSYNC_POL : ~HSYNC_POL;
            r_vsync     <= w_vs_region ? VSYNC_POL : ~VSYNC_POL;
            r_de        <= w_active;
            r_rgb       <= w_show ? pix_tdata : BLANK_COLOR;
            r_sof       <= w_sof;
            r_underflow <= w_underflow;
            r_sync_err  <= w_sync_err;
        end
    end

    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;
    assign r         = r_rgb[COLOR_W-1:0];
    assign g         = r_rgb[2*COLOR_W-1:COLOR_W];
    assign b         = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign sof       = r_sof;
    assign underflow = r_underflow;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_vga_stream_out.sv
// Randomised bench for vga_stream_out with small raster timing and a position-based
// reference model of the stream lock rules.
module tb_vga_stream_out;

    localparam int CW     = 4;
    localparam int H_RES  = 8;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP   = 1;
    localparam int V_RES  = 4;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 1;
    localparam int H_TOT  = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_RES + V_FP + V_SYNC + V_BP;
    localparam int F_TOT  = H_TOT * V_TOT;
    localparam int BEATS  = H_RES * V_RES;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            pix_tvalid;
    logic            pix_tready;
    logic [3*CW-1:0] pix_tdata;
    logic            pix_tlast;
    logic            pix_tuser;
    logic            hsync;
    logic            vsync;
    logic [CW-1:0]   r;
    logic [CW-1:0]   g;
    logic [CW-1:0]   b;
    logic            de;
    logic            sof;
    logic            underflow;
    logic            sync_err;

    always #5 aclk = ~aclk;

    vga_stream_out #(
        .COLOR_W    (CW),
        .H_RES      (H_RES),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_RES      (V_RES),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .HSYNC_POL  (1'b0),
        .VSYNC_POL  (1'b0),
        .BLANK_COLOR(12'h000)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .pix_tvalid(pix_tvalid),
        .pix_tready(pix_tready),
        .pix_tdata (pix_tdata),
        .pix_tlast (pix_tlast),
        .pix_tuser (pix_tuser),
        .hsync     (hsync),
        .vsync     (vsync),
        .r         (r),
        .g         (g),
        .b         (b),
        .de        (de),
        .sof       (sof),
        .underflow (underflow),
        .sync_err  (sync_err)
    );

    typedef struct packed {
        logic [3*CW-1:0] data;
        logic            user;
        logic            last;
    } beat_t;

    beat_t       q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_pos;
    bit          m_locked;
    int          gap_pos;
    int          gap_pct;
    int          step_no = 0;
    // {tready, de, hsync, vsync, b, g, r, sof, underflow, sync_err}
    logic [18:0] obs;
    logic [18:0] exp_v;

    task automatic push_frame(input int mode, input int idx, input bit rnd);
        beat_t bt;
        for (int i = 0; i < BEATS; i++) begin
            bt.data = rnd ? 12'($urandom) : 12'(i);
            bt.user = (i == 0);
            bt.last = (i % H_RES == H_RES - 1);
            if (i == idx) begin
                case (mode)
                    1:       bt.last = 1'b1;
                    2:       bt.last = 1'b0;
                    3:       bt.user = 1'b1;
                    default: ;
                endcase
            end
            q.push_back(bt);
        end
    endtask

    task automatic push_garbage(input int n);
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            bt.data = 12'($urandom);
            bt.user = 1'b0;
            bt.last = 1'($urandom_range(0, 1));
            q.push_back(bt);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_locked = 1'b0;
        gap_pos  = -1;
        gap_pct  = 0;
    endtask

    // One pixel clock: drive head beat, predict from raster position, sample DUT.
    task automatic step();
        bit              gap, v, hs, act, org, rdy, show, uf, err, sof_e;
        beat_t           hd;
        int              h, vv;
        logic [3*CW-1:0] col;
        h   = m_pos % H_TOT;
        vv  = m_pos / H_TOT;
        gap = (m_pos == gap_pos) || (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct);
        if (m_pos == gap_pos) gap_pos = -1;
        v  = (q.size() > 0) && !gap;
        hd = (q.size() > 0) ? q[0] : '0;
        pix_tvalid = v;
        pix_tdata  = hd.data;
        pix_tuser  = hd.user;
        pix_tlast  = hd.last;

        act  = (h < H_RES) && (vv < V_RES);
        org  = (m_pos == 0);
        show = 1'b0;
        uf   = 1'b0;
        err  = 1'b0;
        if (!m_locked) begin
            rdy = !(v && hd.user) || org;
            if (v && hd.user && org) begin
                show     = 1'b1;
                m_locked = 1'b1;
            end
        end else begin
            rdy = act;
            if (act && !v) begin
                uf       = 1'b1;
                m_locked = 1'b0;
            end else if (act) begin
                show = 1'b1;
                if (hd.user != org || hd.last != (h == H_RES - 1)) begin
                    err      = 1'b1;
                    m_locked = 1'b0;
                end
            end
        end
        col   = show ? hd.data : 12'h000;
        sof_e = show && org && hd.user;
        exp_v = {rdy, act, !(h >= H_RES + H_FP && h < H_RES + H_FP + H_SYNC),
                 !(vv >= V_RES + V_FP && vv < V_RES + V_FP + V_SYNC), col, sof_e, uf, err};

        #1;
        obs[18] = pix_tready;
        hs      = pix_tvalid && pix_tready;
        @(posedge aclk);
        #1;
        obs[17:0] = {de, hsync, vsync, b, g, r, sof, underflow, sync_err};
        if (hs) void'(q.pop_front());
        m_pos = (m_pos + 1) % F_TOT;
        step_no++;
        @(negedge aclk);
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        aresetn    = 1'b0;
        pix_tvalid = 1'b0;
        q.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        aresetn    = 1'b0;
        pix_tvalid = 1'b0;
        pix_tdata  = '0;
        pix_tuser  = 1'b0;
        pix_tlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_checks++;
            if ({de, hsync, vsync, b, g, r, sof, underflow, sync_err} !== 18'h18000) begin
                n_errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", i,
                         {de, hsync, vsync, b, g, r, sof, underflow, sync_err}, 18'h18000);
            end
            n_checks++;
            if (pix_tready !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_tready cycle %0d: got %b want 1", i, pix_tready);
            end
        end
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic test_free_run();
        int de_n = 0, hs_n = 0, vs_n = 0, sof_n = 0, col_n = 0;
        for (int i = 0; i < 2 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL free_run step %0d: got %h want %h", step_no, obs, exp_v);
            end
            de_n  += int'(obs[17]);
            hs_n  += int'(!obs[16]);
            vs_n  += int'(!obs[15]);
            col_n += int'(obs[14:3] != 12'h000);
            sof_n += int'(obs[2]);
        end
        n_checks++;
        if (de_n != 2 * BEATS) begin
            n_errors++;
            $display("FAIL free_run_de_count: got %0d want %0d", de_n, 2 * BEATS);
        end
        n_checks++;
        if (hs_n != 2 * V_TOT * H_SYNC) begin
            n_errors++;
            $display("FAIL free_run_hsync_count: got %0d want %0d", hs_n, 2 * V_TOT * H_SYNC);
        end
        n_checks++;
        if (vs_n != 2 * V_SYNC * H_TOT) begin
            n_errors++;
            $display("FAIL free_run_vsync_count: got %0d want %0d", vs_n, 2 * V_SYNC * H_TOT);
        end
        n_checks++;
        if (sof_n != 0 || col_n != 0) begin
            n_errors++;
            $display("FAIL free_run_idle: got sof=%0d colour=%0d want 0 0", sof_n, col_n);
        end
    endtask

    task automatic test_lock();
        int sof_at[$];
        int uf_n = 0, err_n = 0, p;
        apply_reset();
        for (int f = 0; f < 3; f++) push_frame(0, -1, 1'b0);
        for (int i = 1; i <= 3 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL lock step %0d: got %h want %h", step_no, obs, exp_v);
            end
            p = (i - 1) % F_TOT;
            if (obs[17]) begin
                n_checks++;
                if (obs[14:3] !== 12'((p / H_TOT) * H_RES + p % H_TOT)) begin
                    n_errors++;
                    $display("FAIL lock_pixel pos %0d: got %h want %h", p, obs[14:3],
                             12'((p / H_TOT) * H_RES + p % H_TOT));
                end
            end
            if (obs[2]) sof_at.push_back(i);
            uf_n  += int'(obs[1]);
            err_n += int'(obs[0]);
        end
        n_checks++;
        if (sof_at.size() != 3) begin
            n_errors++;
            $display("FAIL lock_sof_count: got %0d want 3", sof_at.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (sof_at[k] - sof_at[k-1] != F_TOT) begin
                    n_errors++;
                    $display("FAIL lock_sof_period: got %0d want %0d", sof_at[k] - sof_at[k-1],
                             F_TOT);
                end
            end
        end
        n_checks++;
        if (uf_n != 0 || err_n != 0) begin
            n_errors++;
            $display("FAIL lock_no_errors: got uf=%0d err=%0d want 0 0", uf_n, err_n);
        end
    endtask

    task automatic test_garbage();
        int first_sof = -1, sof_n = 0;
        apply_reset();
        push_garbage(5);
        for (int f = 0; f < 2; f++) push_frame(0, -1, 1'b1);
        for (int i = 1; i <= 3 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL garbage step %0d: got %h want %h", step_no, obs, exp_v);
            end
            if (i == 5) begin
                n_checks++;
                if (q.size() != 2 * BEATS) begin
                    n_errors++;
                    $display("FAIL garbage_drained: got %0d queued want %0d", q.size(), 2 * BEATS);
                end
            end
            if (obs[2]) begin
                sof_n++;
                if (first_sof < 0) first_sof = i;
            end
        end
        n_checks++;
        if (first_sof != F_TOT + 1 || sof_n != 2) begin
            n_errors++;
            $display("FAIL garbage_sof: got first=%0d count=%0d want %0d 2", first_sof, sof_n,
                     F_TOT + 1);
        end
    endtask

    task automatic test_underflow();
        int uf_at = -1, uf_n = 0, sof_n = 0;
        apply_reset();
        for (int f = 0; f < 3; f++) push_frame(0, -1, 1'b1);
        gap_pos = H_TOT + 3;
        for (int i = 1; i <= 3 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL underflow step %0d: got %h want %h", step_no, obs, exp_v);
            end
            if (obs[1]) begin
                uf_n++;
                uf_at = i;
            end
            sof_n += int'(obs[2]);
        end
        n_checks++;
        if (uf_n != 1 || uf_at != H_TOT + 4) begin
            n_errors++;
            $display("FAIL underflow_pulse: got count=%0d at=%0d want 1 %0d", uf_n, uf_at,
                     H_TOT + 4);
        end
        n_checks++;
        if (sof_n != 3) begin
            n_errors++;
            $display("FAIL underflow_relock_sof: got %0d want 3", sof_n);
        end
    endtask

    task automatic test_bad_tlast();
        int              err_n = 0, sof_n = 0;
        logic [3*CW-1:0] pix5;
        apply_reset();
        push_frame(1, 5, 1'b1);
        pix5 = q[5].data;
        for (int f = 0; f < 2; f++) push_frame(0, -1, 1'b1);
        for (int i = 1; i <= 3 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL bad_tlast step %0d: got %h want %h", step_no, obs, exp_v);
            end
            if (i == 6) begin
                n_checks++;
                if (obs[0] !== 1'b1 || obs[14:3] !== pix5) begin
                    n_errors++;
                    $display("FAIL bad_tlast_pixel5: got err=%b rgb=%h want 1 %h", obs[0],
                             obs[14:3], pix5);
                end
            end
            err_n += int'(obs[0]);
            sof_n += int'(obs[2]);
        end
        n_checks++;
        if (err_n != 1 || sof_n != 3) begin
            n_errors++;
            $display("FAIL bad_tlast_counts: got err=%0d sof=%0d want 1 3", err_n, sof_n);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        for (int f = 0; f < 2; f++) push_frame(0, -1, 1'b1);
        for (int i = 0; i < 2 * H_TOT + 4; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL midreset_pre step %0d: got %h want %h", step_no, obs, exp_v);
            end
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({de, hsync, vsync, b, g, r, sof, underflow, sync_err} !== 18'h18000) begin
            n_errors++;
            $display("FAIL midreset_async: got %h want %h",
                     {de, hsync, vsync, b, g, r, sof, underflow, sync_err}, 18'h18000);
        end
        pix_tvalid = 1'b0;
        q.delete();
        for (int f = 0; f < 2; f++) push_frame(0, -1, 1'b1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        step();
        n_checks++;
        if (obs[18] !== 1'b1 || obs[2] !== 1'b1 || obs[14:3] !== exp_v[14:3]) begin
            n_errors++;
            $display("FAIL midreset_first_lock: got tready=%b sof=%b rgb=%h want 1 1 %h",
                     obs[18], obs[2], obs[14:3], exp_v[14:3]);
        end
        for (int i = 1; i < 2 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL midreset_post step %0d: got %h want %h", step_no, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int mode, idx;
        apply_reset();
        push_garbage(int'($urandom_range(0, 6)));
        for (int f = 0; f < 6; f++) begin
            mode = int'($urandom_range(0, 3));
            idx  = (mode == 2) ? H_RES * int'($urandom_range(0, V_RES - 1)) + H_RES - 1
                               : int'($urandom_range(1, BEATS - 1));
            push_frame(mode, idx, 1'b1);
        end
        gap_pct = 2;
        for (int i = 0; i < 7 * F_TOT; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL random step %0d: got %h want %h", step_no, obs, exp_v);
            end
        end
        gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_lock();
        test_garbage();
        test_underflow();
        test_bad_tlast();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
